// File: rtl/router_pkg.sv
// Shared definitions for the router receive path.
// Holds the packet field offsets, the SIZE field width, the receiver FSM state
// encoding and the CRC-8 polynomial used by the optional CRC check.
package router_pkg;

  // Byte offsets of the header fields within a slot.
  localparam int unsigned OFF_SRC_ID = 0;
  localparam int unsigned OFF_DST_ID = 1;
  localparam int unsigned OFF_SIZE   = 2;
  localparam int unsigned OFF_DATA   = 3;

  // Low bits of the SIZE byte that carry the data byte count.
  localparam int unsigned SIZE_BITS = 3;

  // CRC-8, MSB-first, init 0x00, no final XOR.
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StDst  = 3'd1,
    StSize = 3'd2,
    StData = 3'd3,
    StCrc  = 3'd4,
    StDrop = 3'd5
  } rx_state_e;

endpackage

// File: rtl/crc8_byte.sv
// Combinational single-byte CRC-8 update.
// Ports:
//   crc_i  - running CRC before this byte
//   data_i - byte to fold in, MSB first
//   crc_o  - running CRC after this byte
module crc8_byte (
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);
  import router_pkg::*;

  logic [7:0] c;

  // Byte-wide form: fold the whole byte into the register, then run 8 shifts.
  always_comb begin
    c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/packet_receiver.sv
// Packet receiver: parses SRC, DST, SIZE, DATA[0..n-1], CRC from a byte stream
// framed by packet_valid and writes the packet into one buffer slot, one byte
// per address, then commits the slot with a single winc pulse.
//
// Optional feature: define ROUTER_CRC_CHECK_EN to check the CRC byte against a
// running CRC-8 over SRC..last DATA; on mismatch the slot is not committed and
// packet_err pulses instead of winc.
//
// Ports:
//   clk          - clock, all logic on posedge
//   rst          - synchronous active-high reset
//   packet_valid - a packet byte is present on packet_in
//   packet_in    - packet byte
//   wfull        - buffer has no free slot (sampled at SRC only)
//   wen          - registered write strobe
//   waddr_in     - registered byte offset within the slot
//   wdata        - registered byte to write
//   winc         - one-cycle commit pulse, the cycle after the final wen
//   packet_err   - one-cycle pulse: aborted, overlong, dropped or bad CRC
//   busy         - FSM not in IDLE
module packet_receiver #(
  parameter int unsigned UWIDTH    = 8,
  parameter int unsigned PTR_IN_SZ = 4,
  parameter int unsigned SIZE_BITS = router_pkg::SIZE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 packet_valid,
  input  logic [UWIDTH-1:0]    packet_in,
  input  logic                 wfull,
  output logic                 wen,
  output logic [PTR_IN_SZ-1:0] waddr_in,
  output logic [UWIDTH-1:0]    wdata,
  output logic                 winc,
  output logic                 packet_err,
  output logic                 busy
);
  import router_pkg::*;

  rx_state_e              state_q;
  logic [SIZE_BITS-1:0]   size_q;
  logic [SIZE_BITS-1:0]   dcnt_q;
  // Set after the CRC byte; the following cycle decides commit and overlong.
  logic                   commit_pend_q;
  logic                   crc_ok_q;
  logic                   crc_match;

  logic                   wen_q;
  logic [PTR_IN_SZ-1:0]   waddr_q;
  logic [UWIDTH-1:0]      wdata_q;
  logic                   winc_q;
  logic                   err_q;

`ifdef ROUTER_CRC_CHECK_EN
  logic [7:0] crc_q;
  logic [7:0] crc_in;
  logic [7:0] crc_next;

  // A new packet always starts from the init value, whatever crc_q holds.
  assign crc_in    = (state_q == StIdle) ? 8'h00 : crc_q;
  assign crc_match = (packet_in[7:0] == crc_q);

  crc8_byte u_crc8_byte (
    .crc_i  (crc_in),
    .data_i (packet_in[7:0]),
    .crc_o  (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else if (packet_valid && (state_q inside {StIdle, StDst, StSize, StData})) begin
      crc_q <= crc_next;
    end
  end
`else
  assign crc_match = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      size_q        <= '0;
      dcnt_q        <= '0;
      commit_pend_q <= 1'b0;
      crc_ok_q      <= 1'b0;
      wen_q         <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      winc_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      winc_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (commit_pend_q) begin
            // The cycle after the CRC byte: commit, and catch an overlong packet.
            commit_pend_q <= 1'b0;
            winc_q        <= crc_ok_q;
            if (!crc_ok_q) begin
              err_q <= 1'b1;
            end
            if (packet_valid) begin
              err_q   <= 1'b1;
              state_q <= StDrop;
            end
          end else if (packet_valid) begin
            if (wfull) begin
              err_q   <= 1'b1;
              state_q <= StDrop;
            end else begin
              wen_q   <= 1'b1;
              waddr_q <= PTR_IN_SZ'(OFF_SRC_ID);
              wdata_q <= packet_in;
              state_q <= StDst;
            end
          end
        end
        StDst: begin
          if (packet_valid) begin
            wen_q   <= 1'b1;
            waddr_q <= PTR_IN_SZ'(OFF_DST_ID);
            wdata_q <= packet_in;
            state_q <= StSize;
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StSize: begin
          if (packet_valid) begin
            wen_q   <= 1'b1;
            waddr_q <= PTR_IN_SZ'(OFF_SIZE);
            wdata_q <= packet_in;
            size_q  <= packet_in[SIZE_BITS-1:0];
            dcnt_q  <= packet_in[SIZE_BITS-1:0];
            state_q <= (packet_in[SIZE_BITS-1:0] != '0) ? StData : StCrc;
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StData: begin
          if (packet_valid) begin
            wen_q   <= 1'b1;
            waddr_q <= PTR_IN_SZ'(OFF_DATA) + PTR_IN_SZ'(size_q - dcnt_q);
            wdata_q <= packet_in;
            dcnt_q  <= dcnt_q - 1'b1;
            if (dcnt_q == SIZE_BITS'(1)) begin
              state_q <= StCrc;
            end
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StCrc: begin
          if (packet_valid) begin
            wen_q         <= 1'b1;
            waddr_q       <= PTR_IN_SZ'(OFF_DATA) + PTR_IN_SZ'(size_q);
            wdata_q       <= packet_in;
            crc_ok_q      <= crc_match;
            commit_pend_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StDrop: begin
          if (!packet_valid) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wen        = wen_q;
  assign waddr_in   = waddr_q;
  assign wdata      = wdata_q;
  assign winc       = winc_q;
  assign packet_err = err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_packet_receiver.sv
// Self-checking bench for packet_receiver: directed scenarios plus randomized
// packets, each compared against a packet-level reference model.
module tb_packet_receiver;

  typedef logic [7:0] bq_t[$];

`ifdef ROUTER_CRC_CHECK_EN
  localparam bit CrcCheck = 1'b1;
`else
  localparam bit CrcCheck = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       packet_valid;
  logic [7:0] packet_in;
  logic       wfull;
  logic       wen;
  logic [3:0] waddr_in;
  logic [7:0] wdata;
  logic       winc;
  logic       packet_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int winc_cyc[$];
  int err_cyc[$];
  int busy_cnt = 0;

  always #5 clk = ~clk;

  packet_receiver #(
    .UWIDTH    (8),
    .PTR_IN_SZ (4),
    .SIZE_BITS (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .packet_valid (packet_valid),
    .packet_in    (packet_in),
    .wfull        (wfull),
    .wen          (wen),
    .waddr_in     (waddr_in),
    .wdata        (wdata),
    .winc         (winc),
    .packet_err   (packet_err),
    .busy         (busy)
  );

  // Event recorder, sampling away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (wen) begin
        wr_addr.push_back(int'(waddr_in));
        wr_data.push_back(int'(wdata));
        wr_cyc.push_back(cyc);
      end
      if (winc) winc_cyc.push_back(cyc);
      if (packet_err) err_cyc.push_back(cyc);
      if (busy) busy_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-8 (poly 0x07, init 0, MSB first, no final XOR).
  function automatic logic [7:0] crc8_ref(input bq_t q, input int len);
    logic [7:0] c = 8'h00;
    logic       fb;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = q[i];
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[k];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  function automatic void clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    winc_cyc.delete();
    err_cyc.delete();
    busy_cnt = 0;
  endfunction

  // Sends L valid cycles (bytes beyond the packet are random filler), then
  // compares the recorded writes/pulses with the packet-level model.
  task automatic run_pkt(input string name, input bq_t bytes, input int len, input bit full);
    int  total;
    int  nwr;
    int  exp_winc;
    int  exp_err;
    bit  crc_ok;
    logic [7:0] sz;
    clear_log();
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      packet_valid = 1'b1;
      packet_in    = (i < bytes.size()) ? bytes[i] : 8'($urandom);
      wfull        = full;
    end
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
    packet_in    = 8'h00;
    wfull        = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reference model.
    if (len >= 3) begin
      sz    = bytes[2];
      total = 4 + int'(sz[2:0]);
    end else begin
      total = 4;
    end
    crc_ok = !CrcCheck || (len >= total && bytes[total-1] == crc8_ref(bytes, total - 1));
    if (full) begin
      nwr = 0; exp_winc = 0; exp_err = 1;
    end else if (len < total) begin
      nwr = len; exp_winc = 0; exp_err = 1;
    end else begin
      nwr      = total;
      exp_winc = crc_ok ? 1 : 0;
      exp_err  = (len > total || !crc_ok) ? 1 : 0;
    end

    chk({name, "_nwr"}, wr_addr.size(), nwr);
    for (int i = 0; i < nwr && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", name, i), wr_addr[i], i);
      chk($sformatf("%s_data%0d", name, i), wr_data[i], int'(bytes[i]));
    end
    chk({name, "_winc"}, winc_cyc.size(), exp_winc);
    chk({name, "_err"}, err_cyc.size(), exp_err);
    if (exp_winc == 1 && winc_cyc.size() == 1 && wr_cyc.size() > 0) begin
      chk({name, "_winc_lat"}, winc_cyc[0] - wr_cyc[wr_cyc.size()-1], 1);
    end
    if (full) chk({name, "_busy_cyc"}, busy_cnt, len);
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  function automatic bq_t make_pkt(input logic [7:0] src, input logic [7:0] dst,
                                   input logic [7:0] size, input bit good_crc);
    bq_t q;
    q.push_back(src);
    q.push_back(dst);
    q.push_back(size);
    for (int i = 0; i < int'(size[2:0]); i++) q.push_back(8'($urandom));
    q.push_back(good_crc ? crc8_ref(q, q.size()) : 8'($urandom));
    return q;
  endfunction

  initial begin
    bq_t p;
    int  total;
    int  len;
    bit  full;
    logic [7:0] crc;

    rst          = 1'b1;
    packet_valid = 1'b0;
    packet_in    = 8'h00;
    wfull        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", int'(wen), 0);
    chk("rst_waddr", int'(waddr_in), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_winc", int'(winc), 0);
    chk("rst_err", int'(packet_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Reset held 2 cycles in the middle of a packet.
    @(posedge clk);
    #1;
    packet_valid = 1'b1; packet_in = 8'h11;
    @(posedge clk); #1 packet_in = 8'h22;
    @(posedge clk); #1 packet_in = 8'h05;
    @(posedge clk); #1 packet_in = 8'h33; rst = 1'b1;
    @(posedge clk); #1 packet_in = 8'h44;
    @(posedge clk); #1;
    chk("mrst_wen", int'(wen), 0);
    chk("mrst_waddr", int'(waddr_in), 0);
    chk("mrst_wdata", int'(wdata), 0);
    chk("mrst_busy", int'(busy), 0);
    rst = 1'b0;
    packet_valid = 1'b0;
    clear_log();
    repeat (4) @(posedge clk);
    #1;
    chk("mrst_nowinc", winc_cyc.size(), 0);
    chk("mrst_noerr", err_cyc.size(), 0);

    // Directed: 3-byte data packet.
    p = {8'h05, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    crc = crc8_ref(p, 6);
    p.push_back(crc);
    run_pkt("p3", p, 7, 1'b0);

    // Directed: SIZE=0.
    p = {8'h01, 8'h04, 8'h00};
    crc = crc8_ref(p, 3);
    p.push_back(crc);
    run_pkt("p0", p, 4, 1'b0);

    // Directed: buffer full at SRC, 6-byte stream.
    p = {8'h05, 8'h02, 8'h02, 8'h10, 8'h20, 8'h30};
    run_pkt("full", p, 6, 1'b1);

    // Directed: valid falls after 2nd DATA byte of a SIZE=4 packet.
    p = make_pkt(8'h07, 8'h01, 8'h04, 1'b1);
    run_pkt("short", p, 5, 1'b0);

    // Directed: overlong by two bytes.
    p = make_pkt(8'h02, 8'h03, 8'h01, 1'b1);
    run_pkt("long", p, 7, 1'b0);

    // CRC vectors over an all-zero header (CRC of zeros is zero).
    p = {8'h00, 8'h00, 8'h00, 8'h00};
    run_pkt("crc_ok", p, 4, 1'b0);
    p = {8'h00, 8'h00, 8'h00, 8'h01};
    run_pkt("crc_bad", p, 4, 1'b0);

    // Randomized packets: complete, truncated, overlong, dropped, bad CRC.
    for (int t = 0; t < 30; t++) begin
      p     = make_pkt(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      total = p.size();
      full  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, total - 1);
        1:       len = total + $urandom_range(1, 3);
        default: len = total;
      endcase
      run_pkt($sformatf("rnd%0d", t), p, len, full);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
